// File: rtl/ad2_sweep_sequencer.sv
// ad2_sweep_sequencer: sweeps masked ADC channels over an I2C command/response master and reports results.
module ad2_sweep_sequencer #(
    parameter logic [6:0] DEV_ADDR = 7'h28,
    parameter int         TIMEOUT  = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  ch_mask,
    output logic        busy,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [2:0]  cmd,
    output logic [7:0]  cmd_wdata,
    input  logic        rsp_valid,
    input  logic        rsp_ack,
    input  logic [7:0]  rsp_rdata,
    output logic        res_valid,
    output logic [1:0]  res_channel,
    output logic [11:0] res_data,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        done
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, SEL, ISSUE, WAIT, CHECK, PUBLISH, DONE} state_t;
    state_t state, state_n;
    logic [3:0] pend, idx;
    logic [1:0] ch, low;
    logic [CW-1:0] cnt;
    logic [3:0] hi_q;
    logic [7:0] lo_q, wdata;
    logic [2:0] code;
    logic bad, skip, tmo, tmo_hit, nack, hi_bad;
    always_comb begin
        code  = 3'd4;
        wdata = 8'h00;
        case (idx)
            4'd0, 4'd4: code = 3'd0;
            4'd1: begin code = 3'd1; wdata = {DEV_ADDR, 1'b0}; end
            4'd2: begin code = 3'd1; wdata = 8'h10 << ch; end
            4'd5: begin code = 3'd1; wdata = {DEV_ADDR, 1'b1}; end
            4'd6: code = 3'd2;
            4'd7: code = 3'd3;
            default: code = 3'd4;
        endcase
    end
    assign low       = pend[0] ? 2'd0 : pend[1] ? 2'd1 : pend[2] ? 2'd2 : 2'd3;
    assign tmo_hit   = cnt == CW'(TIMEOUT - 1);
    assign nack      = code == 3'd1 && !rsp_ack;
    assign hi_bad    = idx == 4'd6 && (rsp_rdata[7:6] != 2'b00 || rsp_rdata[5:4] != ch);
    assign busy      = state != IDLE;
    assign cmd_valid = state == ISSUE;
    assign cmd       = cmd_valid ? code : 3'd0;
    assign cmd_wdata = cmd_valid ? wdata : 8'h00;
    assign res_valid = state == PUBLISH;
    assign done      = state == DONE;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? SEL : IDLE;
            SEL:     state_n = pend == 4'd0 ? DONE : ISSUE;
            ISSUE:   state_n = cmd_ready ? WAIT : ISSUE;
            WAIT:    state_n = rsp_valid ? (idx == 4'd8 ? (bad ? SEL : PUBLISH) : CHECK) : (tmo_hit ? CHECK : WAIT);
            CHECK:   state_n = tmo ? DONE : ISSUE;
            PUBLISH: state_n = SEL;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pend        <= 4'd0;
            idx         <= 4'd0;
            ch          <= 2'd0;
            cnt         <= '0;
            hi_q        <= 4'd0;
            lo_q        <= 8'd0;
            bad         <= 1'b0;
            skip        <= 1'b0;
            tmo         <= 1'b0;
            err         <= 1'b0;
            err_code    <= 2'd0;
            res_channel <= 2'd0;
            res_data    <= 12'd0;
        end else begin
            state <= state_n;
            err   <= 1'b0;
            cnt   <= state == WAIT ? cnt + 1'b1 : '0;
            if (state == IDLE && start) begin
                pend <= ch_mask;
                tmo  <= 1'b0;
            end
            if (state == SEL && pend != 4'd0) begin
                ch   <= low;
                pend <= pend & (pend - 4'd1);
                idx  <= 4'd0;
                bad  <= 1'b0;
                skip <= 1'b0;
            end
            if (state == WAIT && rsp_valid) begin
                if (idx == 4'd6) hi_q <= rsp_rdata[3:0];
                if (idx == 4'd7) lo_q <= rsp_rdata;
                if (nack || hi_bad) begin
                    err      <= 1'b1;
                    err_code <= nack ? 2'd1 : 2'd2;
                    bad      <= 1'b1;
                    skip     <= nack;
                end
                if (idx == 4'd8 && !bad) begin
                    res_channel <= ch;
                    res_data    <= {hi_q, lo_q};
                end
            end else if (state == WAIT && tmo_hit) begin
                err      <= 1'b1;
                err_code <= 2'd3;
                tmo      <= 1'b1;
            end
            // a NACKed write jumps straight to the closing STOP
            if (state == CHECK) idx <= skip ? 4'd8 : idx + 4'd1;
        end
    end
endmodule

// File: tb/tb_ad2_sweep_sequencer.sv
// tb_ad2_sweep_sequencer: scoreboard bench with an I2C master model for ad2_sweep_sequencer.
module tb_ad2_sweep_sequencer;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [3:0] ch_mask = 4'd0;
    logic busy, cmd_valid, cmd_ready, rsp_valid, rsp_ack, res_valid, err, done;
    logic [2:0] cmd;
    logic [7:0] cmd_wdata, rsp_rdata;
    logic [1:0] res_channel, err_code;
    logic [11:0] res_data;

    ad2_sweep_sequencer #(.DEV_ADDR(7'h28), .TIMEOUT(50)) dut (
        .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask), .busy(busy),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_rdata(rsp_rdata),
        .res_valid(res_valid), .res_channel(res_channel), .res_data(res_data),
        .err(err), .err_code(err_code), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [10:0] exp_cmd[$];
    logic [15:0] exp_evt[$];
    logic [7:0] hi_tab[4], lo_tab[4];
    int ncmd = 0, nack_num = -1, hold_num = -1, stall_at = -1, stall_left = 0;
    int pend_cnt = 0, hs_cyc = 0, ndone = 0, last_err_cyc = 0, last_done_cyc = 0, start_cyc = 0;
    bit saw_rdack = 0;
    logic [7:0] pend_data = 8'd0;
    logic pend_ack = 1'b0;
    logic [1:0] cur_ch = 2'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // master model: owns cmd_ready and the response bus
    initial begin
        cmd_ready = 1'b1;
        rsp_valid = 1'b0;
        rsp_ack = 1'b0;
        rsp_rdata = 8'd0;
        forever begin
            @(negedge clk);
            rsp_valid = 1'b0;
            rsp_ack = 1'b0;
            rsp_rdata = 8'd0;
            if (rst) pend_cnt = 0;
            else if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    rsp_valid = 1'b1;
                    rsp_ack = pend_ack;
                    rsp_rdata = pend_data;
                end
            end
            if (cmd_valid && stall_at == ncmd && stall_left > 0) begin
                cmd_ready = 1'b0;
                stall_left--;
                if (exp_cmd.size() == 0) miss("stall_cmd");
                else chk("stall_cmd", {cmd, cmd_wdata}, exp_cmd[0]);
            end else cmd_ready = 1'b1;
            if (cmd_valid && cmd_ready && !rst) begin
                if (exp_cmd.size() == 0) miss("cmd_extra");
                else chk("cmd", {cmd, cmd_wdata}, exp_cmd.pop_front());
                if (cmd == 3'd1)
                    case (cmd_wdata)
                        8'h10: cur_ch = 2'd0;
                        8'h20: cur_ch = 2'd1;
                        8'h40: cur_ch = 2'd2;
                        8'h80: cur_ch = 2'd3;
                        default: ;
                    endcase
                pend_ack = ncmd != nack_num;
                pend_data = cmd == 3'd2 ? hi_tab[cur_ch] : cmd == 3'd3 ? lo_tab[cur_ch] : 8'd0;
                if (cmd == 3'd2) saw_rdack = 1;
                pend_cnt = ncmd == hold_num ? 0 : 3;
                hs_cyc = cyc;
                ncmd++;
            end
        end
    end

    // monitor: pops the expected event stream whenever a pulse appears
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && (res_valid || err || done)) begin
                chk("excl", int'(res_valid) + int'(err) + int'(done), 1);
                if (exp_evt.size() == 0) miss("evt_extra");
                else if (res_valid) chk("res", {2'd0, res_channel, res_data}, exp_evt.pop_front());
                else if (err) chk("err", {2'd1, 12'd0, err_code}, exp_evt.pop_front());
                else chk("done", {2'd2, 14'd0}, exp_evt.pop_front());
                if (err) last_err_cyc = cyc;
                if (done) begin
                    last_done_cyc = cyc;
                    ndone++;
                end
            end
        end
    end

    task automatic push_ch(input int n, input int upto);
        logic [10:0] seq[9];
        logic [7:0] cfg;
        cfg = 8'h10 << n;
        seq = '{{3'd0, 8'h00}, {3'd1, 8'h50}, {3'd1, cfg}, {3'd4, 8'h00}, {3'd0, 8'h00},
                {3'd1, 8'h51}, {3'd2, 8'h00}, {3'd3, 8'h00}, {3'd4, 8'h00}};
        for (int i = 0; i <= upto; i++) exp_cmd.push_back(seq[i]);
    endtask

    task automatic run(input logic [3:0] m);
        @(negedge clk);
        ch_mask = m;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (ndone < 1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (ndone < 1) miss("done_timeout");
        repeat (2) @(negedge clk);
    endtask

    task automatic finish_scn(input string name, input int cmds);
        chk({name, "_cmds_left"}, exp_cmd.size(), 0);
        chk({name, "_evts_left"}, exp_evt.size(), 0);
        chk({name, "_ncmd"}, ncmd, cmds);
        chk({name, "_ndone"}, ndone, 1);
        ncmd = 0;
        ndone = 0;
        nack_num = -1;
        hold_num = -1;
        stall_at = -1;
        exp_cmd.delete();
        exp_evt.delete();
    endtask

    function automatic logic [31:0] outs();
        return {busy, cmd_valid, cmd, cmd_wdata, res_valid, res_channel, res_data, err, err_code, done};
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 32'd0);
        rst = 1'b0;

        hi_tab = '{8'h0A, 8'h00, 8'h25, 8'h00};
        lo_tab = '{8'hBC, 8'h00, 8'h01, 8'h00};
        push_ch(0, 8);
        push_ch(2, 8);
        exp_evt = '{{2'd0, 2'd0, 12'hABC}, {2'd0, 2'd2, 12'h501}, {2'd2, 14'd0}};
        run(4'b0101);
        wait_done();
        finish_scn("sweep", 18);

        nack_num = 11;
        push_ch(0, 8);
        push_ch(1, 2);
        exp_cmd.push_back({3'd4, 8'h00});
        exp_evt = '{{2'd0, 2'd0, 12'hABC}, {2'd1, 14'd1}, {2'd2, 14'd0}};
        run(4'b0011);
        wait_done();
        finish_scn("nack", 13);

        hi_tab[3] = 8'h1F;
        lo_tab[3] = 8'h99;
        push_ch(3, 8);
        exp_evt = '{{2'd1, 14'd2}, {2'd2, 14'd0}};
        run(4'b1000);
        wait_done();
        finish_scn("chid", 9);

        hold_num = 0;
        push_ch(1, 0);
        exp_evt = '{{2'd1, 14'd3}, {2'd2, 14'd0}};
        run(4'b0010);
        wait_done();
        chk("tmo_err_cycle", last_err_cyc - hs_cyc, 51);
        chk("tmo_done_cycle", last_done_cyc - last_err_cyc, 1);
        chk("tmo_idle", {busy, cmd_valid}, 2'b00);
        finish_scn("tmo", 1);

        hi_tab[0] = 8'h03;
        lo_tab[0] = 8'h7F;
        stall_at = 1;
        stall_left = 7;
        push_ch(0, 8);
        exp_evt = '{{2'd0, 2'd0, 12'h37F}, {2'd2, 14'd0}};
        run(4'b0001);
        repeat (2) @(negedge clk);
        ch_mask = 4'b1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        chk("stall_left", stall_left, 0);
        finish_scn("stall", 9);

        exp_evt = '{{2'd2, 14'd0}};
        run(4'b0000);
        wait_done();
        chk("mask0_done_cycle", last_done_cyc - start_cyc, 2);
        finish_scn("mask0", 0);

        push_ch(0, 8);
        run(4'b0001);
        for (int k = 0; k < 500 && !saw_rdack; k++) @(negedge clk);
        if (!saw_rdack) miss("rdack_timeout");
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_outputs", outs(), 32'd0);
        rst = 1'b0;
        exp_cmd.delete();
        exp_evt.delete();
        ncmd = 0;
        hi_tab[1] = 8'h1C;
        lo_tab[1] = 8'h44;
        push_ch(1, 8);
        exp_evt = '{{2'd0, 2'd1, 12'hC44}, {2'd2, 14'd0}};
        run(4'b0010);
        wait_done();
        finish_scn("after_rst", 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
